// File: rtl/modbus_input_reg_scan_if.sv
// Sample request/acknowledge channel between the input-register scanner and
// the sensor front end.
//   smp_req   scanner -> sensor  request, held until ack or timeout
//   smp_ch    scanner -> sensor  channel index 0..11, stable while smp_req=1
//   smp_ack   sensor -> scanner  1-cycle acknowledge, smp_data valid with it
//   smp_data  sensor -> scanner  16-bit sample value
interface modbus_input_reg_scan_if;
    logic        smp_req;
    logic [3:0]  smp_ch;
    logic        smp_ack;
    logic [15:0] smp_data;

    modport master (
        output smp_req,
        output smp_ch,
        input  smp_ack,
        input  smp_data
    );

    modport slave (
        input  smp_req,
        input  smp_ch,
        output smp_ack,
        output smp_data
    );
endinterface

// File: rtl/modbus_input_reg_scan.sv
// Input-register scanner for the Modbus RTU slave (function 04).
// On every scan-period tick (while idle and enabled) polls channels 0..11 over
// the sample interface into a shadow bank, then copies the whole bank to
// read_04_bus in one cycle once freeze is low, so a response never mixes scans.
// Optional build macro AVG4_EN: each channel is sampled four times and the
// truncated mean is stored; any timeout marks the channel bad (16'hFFFF).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   scan_en        enables starting a scan on a tick
//   freeze         holds the commit while a slave transaction is running
//   smp            sample interface (master side)
//   read_04_bus    committed bank, channel k at [16k+15:16k]
//   scan_done      1-cycle pulse, aligned with the new read_04_bus contents
//   ch_err         per-channel timeout flags of the last committed scan
//   overrun        sticky: a tick arrived while a scan was still running
module modbus_input_reg_scan #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned SCAN_PERIOD = 1000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scan_en,
    input  logic                     freeze,
    modbus_input_reg_scan_if.master  smp,
    output logic [191:0]             read_04_bus,
    output logic                     scan_done,
    output logic [11:0]              ch_err,
    output logic                     overrun
);

    localparam int unsigned Ticks   = (CLK_FREQ / 1000000) * SCAN_PERIOD;
    localparam int unsigned PerW    = (Ticks > 1) ? $clog2(Ticks) : 1;
    localparam logic [PerW-1:0] PerLast = PerW'(Ticks - 1);
    localparam logic [15:0] WaitLast    = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StNext, StCommit} state_e;

    state_e state_q, state_d;

    logic [PerW-1:0] per_q;
    logic [15:0]     wait_q;
    logic [3:0]      idx_q;
    logic [15:0]     shadow_q [12];
    logic [11:0]     err_sh_q;
    logic [191:0]    bus_q;
    logic [11:0]     ch_err_q;
    logic            scan_done_q;
    logic            overrun_q;

    logic tick, start, ack_hit, timeout;
    logic more;      // in NEXT: another sample of the same channel is pending
    logic ch_done;   // final result for the current channel is written this cycle
    logic [15:0] ch_val;

    assign tick    = (per_q == PerLast);
    assign start   = (state_q == StIdle) && tick && scan_en;
    assign ack_hit = (state_q == StReq) && smp.smp_ack;
    // Ack on the last allowed cycle wins over the timeout.
    assign timeout = (state_q == StReq) && !smp.smp_ack && (wait_q == WaitLast);

`ifdef AVG4_EN
    logic [1:0]  rep_q;
    logic [17:0] sum_q, sum_nx;

    assign sum_nx  = sum_q + {2'b00, smp.smp_data};
    assign more    = (rep_q != 2'd0);
    assign ch_done = timeout || (ack_hit && rep_q == 2'd3);
    assign ch_val  = timeout ? 16'hFFFF : 16'(sum_nx >> 2);

    // A timeout abandons the remaining samples of the channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_q <= 2'd0;
            sum_q <= 18'd0;
        end else if (ch_done) begin
            rep_q <= 2'd0;
            sum_q <= 18'd0;
        end else if (ack_hit) begin
            rep_q <= rep_q + 2'd1;
            sum_q <= sum_nx;
        end
    end
`else
    assign more    = 1'b0;
    assign ch_done = ack_hit || timeout;
    assign ch_val  = timeout ? 16'hFFFF : smp.smp_data;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StReq;
            StReq:    if (ack_hit || timeout) state_d = StNext;
            StNext:   state_d = (more || idx_q != 4'd11) ? StReq : StCommit;
            StCommit: if (!freeze) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        smp.smp_req = (state_q == StReq);
        smp.smp_ch  = idx_q;
        read_04_bus = bus_q;
        ch_err      = ch_err_q;
        scan_done   = scan_done_q;
        overrun     = overrun_q;
    end

    // Datapath: period counter, wait counter, channel index, shadow and output banks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_q       <= '0;
            wait_q      <= 16'd0;
            idx_q       <= 4'd0;
            err_sh_q    <= 12'd0;
            bus_q       <= 192'd0;
            ch_err_q    <= 12'd0;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < 12; k++) begin
                shadow_q[k] <= 16'd0;
            end
        end else begin
            per_q       <= tick ? '0 : per_q + 1'b1;
            wait_q      <= (state_q == StReq && !(ack_hit || timeout)) ? wait_q + 16'd1 : 16'd0;
            scan_done_q <= 1'b0;

            // Ticks arriving mid-scan are dropped, only flagged.
            if (tick && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end

            if (start) begin
                idx_q    <= 4'd0;
                err_sh_q <= 12'd0;
            end else if (state_q == StNext && !more && idx_q != 4'd11) begin
                idx_q <= idx_q + 4'd1;
            end

            if (ch_done) begin
                shadow_q[idx_q] <= ch_val;
                if (timeout) begin
                    err_sh_q[idx_q] <= 1'b1;
                end
            end

            if (state_q == StCommit && !freeze) begin
                for (int k = 0; k < 12; k++) begin
                    bus_q[16*k +: 16] <= shadow_q[k];
                end
                ch_err_q    <= err_sh_q;
                scan_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modbus_input_reg_scan.sv
module tb_modbus_input_reg_scan;

    localparam int unsigned ClkFreq    = 1000000;
    localparam int unsigned ScanPeriod = 150;
    localparam int unsigned AckTo      = 16;
    localparam int          Ticks      = int'((ClkFreq / 1000000) * ScanPeriod);
`ifdef AVG4_EN
    localparam int Reps = 4;
`else
    localparam int Reps = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scan_en = 1'b0;
    logic         freeze = 1'b0;
    logic [191:0] read_04_bus;
    logic         scan_done;
    logic [11:0]  ch_err;
    logic         overrun;

    modbus_input_reg_scan_if smp_if ();

    modbus_input_reg_scan #(
        .CLK_FREQ    (ClkFreq),
        .SCAN_PERIOD (ScanPeriod),
        .ACK_TIMEOUT (AckTo)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .freeze      (freeze),
        .smp         (smp_if),
        .read_04_bus (read_04_bus),
        .scan_done   (scan_done),
        .ch_err      (ch_err),
        .overrun     (overrun)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int           pc;
    logic         busy, abort;
    logic         s_rst, s_en, s_frz, s_ack, s_tick;
    logic [15:0]  s_data;
    logic [15:0]  m_shadow [12];
    logic [11:0]  m_err;
    logic [191:0] exp_bus = '0;
    logic [11:0]  exp_err = '0;
    logic         exp_done = 1'b0, exp_ovr = 1'b0, exp_req = 1'b0;
    logic [3:0]   exp_ch = 4'd0;

    // One clock edge: capture what the DUT sees, advance the period count.
    task automatic step();
        @(posedge clk);
        s_rst  = rst_n;
        s_en   = scan_en;
        s_frz  = freeze;
        s_ack  = smp_if.smp_ack;
        s_data = smp_if.smp_data;
        s_tick = (pc == Ticks - 1);
        exp_done = 1'b0;
        if (!s_rst) begin
            pc = 0; busy = 1'b0; abort = 1'b1;
            exp_bus = '0; exp_err = '0; exp_ovr = 1'b0; exp_req = 1'b0; exp_ch = 4'd0;
            for (int k = 0; k < 12; k++) m_shadow[k] = 16'd0;
        end else begin
            pc = s_tick ? 0 : pc + 1;
            if (s_tick && busy) exp_ovr = 1'b1;
        end
    endtask

    task automatic run_model();
        logic [17:0] sum;
        logic bad, got;
        pc = 0; busy = 1'b0; abort = 1'b0;
        for (int k = 0; k < 12; k++) m_shadow[k] = 16'd0;
        forever begin
            busy = 1'b0;
            do step(); while (!(s_rst && s_tick && s_en));
            busy = 1'b1; abort = 1'b0; m_err = '0;
            for (int ch = 0; ch < 12 && !abort; ch++) begin
                sum = '0; bad = 1'b0;
                for (int r = 0; r < Reps && !abort && !bad; r++) begin
                    exp_req = 1'b1; exp_ch = 4'(ch); got = 1'b0;
                    for (int w = 0; w < int'(AckTo) && !abort && !got; w++) begin
                        step();
                        if (!abort && s_ack) begin
                            got = 1'b1;
                            sum = sum + {2'b00, s_data};
                        end
                    end
                    if (abort) break;
                    exp_req = 1'b0;
                    if (!got) bad = 1'b1;
                    step();  // gap cycle between requests
                end
                if (!abort) begin
                    m_shadow[ch] = bad ? 16'hFFFF : ((Reps == 4) ? sum[17:2] : sum[15:0]);
                    m_err[ch] = bad;
                end
            end
            if (abort) continue;
            do step(); while (!abort && s_frz);
            if (abort) continue;
            for (int k = 0; k < 12; k++) exp_bus[16*k +: 16] = m_shadow[k];
            exp_err = m_err;
            exp_done = 1'b1;
        end
    endtask

    initial run_model();

    // Compare every cycle once out of the initial reset
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("bus", read_04_bus, exp_bus);
            chk("ch_err", {180'd0, ch_err}, {180'd0, exp_err});
            chk("scan_done", {191'd0, scan_done}, {191'd0, exp_done});
            chk("overrun", {191'd0, overrun}, {191'd0, exp_ovr});
            chk("smp_req", {191'd0, smp_if.smp_req}, {191'd0, exp_req});
            if (exp_req) chk("smp_ch", {188'd0, smp_if.smp_ch}, {188'd0, exp_ch});
        end
    end

    // ---------------- sensor responder ----------------
    int   lat_mode = 3;    // <0: random 0..5 cycles
    int   dead_ch = -1;
    logic dead_all = 1'b0;
    int   data_mode = 0;   // 0: 1000+ch, 1: random, 2: 1,2,3.. per channel, 3: FFFF
    logic en_rand = 1'b0;

    initial begin
        int cnt = 0, lat = 0, last_ch = -1, nack = 0;
        smp_if.smp_ack  = 1'b0;
        smp_if.smp_data = 16'd0;
        forever begin
            @(negedge clk);
            smp_if.smp_ack = 1'b0;
            if (!smp_if.smp_req) begin
                cnt = 0;
                lat = (lat_mode < 0) ? int'($urandom_range(5, 0)) : lat_mode;
                if ($urandom_range(7, 0) == 0) begin
                    smp_if.smp_ack  = 1'b1;  // stray ack, must be ignored
                    smp_if.smp_data = 16'($urandom);
                end
            end else begin
                if (int'(smp_if.smp_ch) != last_ch) begin
                    last_ch = int'(smp_if.smp_ch);
                    nack = 0;
                end
                if (cnt == lat && !dead_all && int'(smp_if.smp_ch) != dead_ch) begin
                    smp_if.smp_ack = 1'b1;
                    case (data_mode)
                        0:       smp_if.smp_data = 16'h1000 + 16'(smp_if.smp_ch);
                        1:       smp_if.smp_data = 16'($urandom);
                        2:       smp_if.smp_data = 16'(nack + 1);
                        default: smp_if.smp_data = 16'hFFFF;
                    endcase
                    nack++;
                end
                cnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (en_rand) scan_en = 1'($urandom_range(1, 0));
    end

    // Request length per channel, and scan_done pulse count
    int req_len [12];
    int done_cnt = 0;
    initial begin
        int run = 0, run_ch = 0;
        for (int k = 0; k < 12; k++) req_len[k] = 0;
        forever begin
            @(negedge clk);
            if (scan_done) done_cnt++;
            if (smp_if.smp_req) begin
                run++;
                run_ch = int'(smp_if.smp_ch);
            end else if (run > 0) begin
                if (run_ch < 12) req_len[run_ch] = run;
                run = 0;
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic wait_done(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (scan_done) return;
        end
        vectors++; miscompares++;
        $display("FAIL %s: no scan_done after %0d cycles, required one", name, budget);
    endtask

    task automatic wait_req(input string name, input int ch, input logic level, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (smp_if.smp_req == level && (!level || int'(smp_if.smp_ch) == ch)) return;
        end
        vectors++; miscompares++;
        $display("FAIL %s: smp_req never reached %0b (ch %0d) in %0d cycles", name, level, ch,
                 budget);
    endtask

    initial begin
        int d0;
        int frz_done;
        logic [191:0] bus_before;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_bus", read_04_bus, 192'd0);
        chk("rst_err", {180'd0, ch_err}, 192'd0);
        chk("rst_req", {191'd0, smp_if.smp_req}, 192'd0);
        chk("rst_ch", {188'd0, smp_if.smp_ch}, 192'd0);
        chk("rst_done", {191'd0, scan_done}, 192'd0);
        chk("rst_ovr", {191'd0, overrun}, 192'd0);
        rst_n = 1'b1;
        scan_en = 1'b1;

        // Acks after 3 cycles, data 1000+ch
        d0 = done_cnt;
        wait_done("t1_done", 1500);
        repeat (3) @(negedge clk);
        chk("t1_ch0", {176'd0, read_04_bus[15:0]}, {176'd0, 16'h1000});
        chk("t1_ch11", {176'd0, read_04_bus[191:176]}, {176'd0, 16'h100B});
        chk("t1_err", {180'd0, ch_err}, 192'd0);
        chk("t1_once", 192'(done_cnt - d0), 192'd1);
        chk("t1_reqlen", 192'(req_len[0]), 192'd4);

        // Channel 5 never acked
        dead_ch = 5;
        wait_done("t2_done", 1500);
        @(negedge clk);
        chk("t2_ch5", {176'd0, read_04_bus[95:80]}, {176'd0, 16'hFFFF});
        chk("t2_ch4", {176'd0, read_04_bus[79:64]}, {176'd0, 16'h1004});
        chk("t2_err", {180'd0, ch_err}, {180'd0, 12'h020});
        chk("t2_reqlen", 192'(req_len[5]), 192'd16);

        // Random latency/data, scan_en toggling
        dead_ch = -1; lat_mode = -1; data_mode = 1; en_rand = 1'b1;
        repeat (4) wait_done("t3_done", 3000);
        en_rand = 1'b0; scan_en = 1'b1;
`ifndef AVG4_EN
        chk("t3_ovr", {191'd0, overrun}, 192'd0);
`endif

        // Freeze across end of scan
        lat_mode = 3; data_mode = 0;
        wait_req("t4_start", 0, 1'b1, 1500);
        freeze = 1'b1;
        bus_before = read_04_bus;
        wait_req("t4_ch11", 11, 1'b1, 1500);
        wait_req("t4_ch11_end", 11, 1'b0, 100);
        frz_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (scan_done) frz_done++;
        end
        chk("t4_frz_nodone", 192'(frz_done), 192'd0);
        chk("t4_frz_bus", read_04_bus, bus_before);
        freeze = 1'b0;
        @(negedge clk);
        chk("t4_commit", {191'd0, scan_done}, 192'd1);
        chk("t4_ch3", {176'd0, read_04_bus[63:48]}, {176'd0, 16'h1003});

        // Reset during channel 7 request
        wait_req("t5_ch7", 7, 1'b1, 1500);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_bus", read_04_bus, 192'd0);
        chk("t5_err", {180'd0, ch_err}, 192'd0);
        chk("t5_req", {191'd0, smp_if.smp_req}, 192'd0);
        chk("t5_done", {191'd0, scan_done}, 192'd0);
        chk("t5_ovr", {191'd0, overrun}, 192'd0);
        rst_n = 1'b1;
        wait_done("t5_restart", 1500);
        @(negedge clk);
        chk("t5_ch0", {176'd0, read_04_bus[15:0]}, {176'd0, 16'h1000});

        // All channels time out: scan longer than the period
        dead_all = 1'b1;
        wait_done("t6_done", 1500);
        @(negedge clk);
        chk("t6_ovr", {191'd0, overrun}, 192'd1);
        chk("t6_err", {180'd0, ch_err}, {180'd0, 12'hFFF});
        dead_all = 1'b0;
        wait_done("t6_next", 1500);
        chk("t6_sticky", {191'd0, overrun}, 192'd1);

`ifdef AVG4_EN
        data_mode = 2;
        wait_done("t7_avg", 1500);
        @(negedge clk);
        chk("t7_avg_ch0", {176'd0, read_04_bus[15:0]}, {176'd0, 16'h0002});
        data_mode = 3;
        wait_done("t7_ffff", 1500);
        @(negedge clk);
        chk("t7_ffff_ch0", {176'd0, read_04_bus[15:0]}, {176'd0, 16'hFFFF});
        chk("t7_ffff_err", {191'd0, ch_err[0]}, 192'd0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished",
                 $time);
        $fatal(1, "watchdog");
    end

endmodule
